// File: rtl/y_signature_unit_if.sv
// Handshake/bus bundle between a y_signature_unit and its driver/consumer.
// SIG_CMP_EN adds the expected-signature input and the mismatch flag.
interface y_signature_unit_if #(
  parameter int Y_W   = 241,
  parameter int SIG_W = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_cycles;
  logic [Y_W-1:0]   y_in;
  logic             busy;
  logic [SIG_W-1:0] sig;
  logic             sig_valid;
  logic             sig_ready;
`ifdef SIG_CMP_EN
  logic [SIG_W-1:0] sig_exp;
  logic             mismatch;

  modport master (
    output start, num_cycles, y_in, sig_ready, sig_exp,
    input  busy, sig, sig_valid, mismatch
  );
  modport slave (
    input  start, num_cycles, y_in, sig_ready, sig_exp,
    output busy, sig, sig_valid, mismatch
  );
`else
  modport master (
    output start, num_cycles, y_in, sig_ready,
    input  busy, sig, sig_valid
  );
  modport slave (
    input  start, num_cycles, y_in, sig_ready,
    output busy, sig, sig_valid
  );
`endif
endinterface

// File: rtl/y_signature_unit.sv
// Compresses the DUT y bus into a MISR signature over a programmed window and offers it on
// a valid/ready handshake. Define SIG_CMP_EN to add an on-chip compare against sig_exp.
module y_signature_unit #(
  parameter int               Y_W    = 241,
  parameter int               SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED   = 32'hFFFFFFFF,
  parameter int               CNT_W  = 16,
  parameter int               WARMUP = 2
) (
  input logic              clk,
  input logic              rst,
  y_signature_unit_if.slave bus
);

  localparam int NCHUNK = (Y_W + SIG_W - 1) / SIG_W;
  localparam int PAD_W  = NCHUNK * SIG_W;
  localparam int WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              busy_q;
  logic              valid_q;

  logic [PAD_W-1:0]  y_pad;
  logic [SIG_W-1:0]  fold;
  logic [SIG_W-1:0]  misr_next;

  assign y_pad = PAD_W'(bus.y_in);

  always_comb begin
    fold = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      fold = fold ^ y_pad[k*SIG_W +: SIG_W];
    end
  end

  assign misr_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sig_d  = SEED;
          n_d    = bus.num_cycles;
          cnt_d  = '0;
          wcnt_d = '0;
          if (WARMUP > 0)                state_d = WARM;
          else if (bus.num_cycles == '0) state_d = DONE;
          else                           state_d = ACCUM;
        end
      end
      WARM: begin
        if (wcnt_q == WLAST) state_d = (n_q == '0) ? DONE : ACCUM;
        else                 wcnt_d  = wcnt_q + WCNT_W'(1);
      end
      ACCUM: begin
        sig_d = misr_next;
        // cnt counts samples already taken, so it tops out at N-1 and never wraps.
        if (cnt_q == n_q - CNT_W'(1)) state_d = DONE;
        else                          cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE: begin
        if (bus.sig_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      n_q     <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= (state_d == WARM) || (state_d == ACCUM);
      valid_q <= (state_d == DONE);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.sig       = sig_q;
  assign bus.sig_valid = valid_q;

`ifdef SIG_CMP_EN
  logic mismatch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      mismatch_q <= 1'b0;
    end else if (state_q != DONE && state_d == DONE) begin
      // Compare the final signature as it lands, then hold it through DONE and beyond.
      mismatch_q <= (sig_d != bus.sig_exp);
    end
  end

  assign bus.mismatch = mismatch_q;
`endif

endmodule
